// File: rtl/board_state_ctrl_pkg.sv
// Shared board geometry, cell display codes and FSM encoding for the minesweeper
// board controller, its renderer and the neighbour counter.
package board_state_ctrl_pkg;

  localparam int GRID_W = 16;
  localparam int GRID_H = 16;
  localparam int NCELLS = GRID_W * GRID_H;

  localparam logic [3:0] CELL_HIDDEN   = 4'd9;
  localparam logic [3:0] CELL_FLAG     = 4'd10;
  localparam logic [3:0] CELL_MINE     = 4'd11;
  localparam logic [3:0] CELL_EXPLODED = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_PLAY, ST_REVEAL, ST_FLOOD, ST_WON, ST_LOST
  } state_t;

  // Neighbour k = 0..7 in raster order around the centre cell.
  function automatic int nbr_dx(int k);
    case (k)
      0, 3, 5: return -1;
      1, 6:    return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int nbr_dy(int k);
    return (k < 3) ? -1 : ((k < 5) ? 0 : 1);
  endfunction

endpackage

// File: rtl/board_state_ctrl_if.sv
// Request / status bundle between the cursor+renderer side and the board controller.
interface board_state_ctrl_if;
  import board_state_ctrl_pkg::*;

  logic              new_game;
  logic [NCELLS-1:0] mine_map;
  logic              sel_sqr;
  logic              place_flag;
  logic [7:0]        cursor_addr;
  logic [7:0]        rd_addr;
  logic [3:0]        rd_cell;
  logic              busy;
  logic              game_won;
  logic              game_lost;
  logic [8:0]        flags_placed;
  logic [8:0]        cells_revealed;

  modport master (
    output new_game, mine_map, sel_sqr, place_flag, cursor_addr, rd_addr,
    input  rd_cell, busy, game_won, game_lost, flags_placed, cells_revealed
  );

  modport slave (
    input  new_game, mine_map, sel_sqr, place_flag, cursor_addr, rd_addr,
    output rd_cell, busy, game_won, game_lost, flags_placed, cells_revealed
  );

endinterface

// File: rtl/board_state_ctrl_nbr_count.sv
// Combinational count of set bits of a 16x16 map in the 8-neighbourhood of addr,
// with no wrap at the board edges.
module nbr_count
  import board_state_ctrl_pkg::*;
(
  input  logic [NCELLS-1:0] map,
  input  logic [7:0]        addr,
  output logic [3:0]        count
);

  logic [7:0] hit;

  // A 5-bit sum leaves bit 4 set exactly when the neighbour falls off the board.
  for (genvar k = 0; k < 8; k++) begin : g_nbr
    localparam int DX = nbr_dx(k);
    localparam int DY = nbr_dy(k);
    logic [4:0] nx, ny;
    assign nx     = {1'b0, addr[3:0]} + 5'(DX);
    assign ny     = {1'b0, addr[7:4]} + 5'(DY);
    assign hit[k] = !nx[4] && !ny[4] && map[{ny[3:0], nx[3:0]}];
  end

  always_comb begin
    count = '0;
    for (int k = 0; k < 8; k++) count = count + 4'(hit[k]);
  end

endmodule

// File: rtl/board_state_ctrl.sv
// Minesweeper board owner: mine load, reveal, zero-region flood fill, flag toggling,
// win/loss detection and a registered per-cell read port for the renderer.
module board_state_ctrl
  import board_state_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  board_state_ctrl_if.slave bus
);

  state_t            state, state_nx;
  logic [NCELLS-1:0] mines, revealed, flag, zero;
  logic [7:0]        idx, tgt, work_addr, cur, exploded_addr;
  logic [3:0]        work_cnt, zero_nbrs, rd_cnt, rd_code, rd_cell_q;
  logic [8:0]        mine_total, flags_placed, cells_revealed, cr_next;
  logic              changed, exploded_vld, reveal_en, explode_en, flag_en, win_hit;

  assign cur       = bus.cursor_addr;
  assign work_addr = (state == ST_FLOOD) ? idx : tgt;

  // zero[] marks revealed cells with no mine neighbours; flood adjacency reads it.
  nbr_count u_work_cnt (.map(mines), .addr(work_addr),   .count(work_cnt));
  nbr_count u_zero_adj (.map(zero),  .addr(idx),         .count(zero_nbrs));
  nbr_count u_rd_cnt   (.map(mines), .addr(bus.rd_addr), .count(rd_cnt));

  assign cr_next = cells_revealed + 9'(reveal_en);
  assign win_hit = (cr_next == 9'(NCELLS) - mine_total);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    reveal_en  = 1'b0;
    explode_en = 1'b0;
    flag_en    = 1'b0;
    case (state)
      ST_LOAD: if (idx == 8'hFF) state_nx = ST_PLAY;
      ST_PLAY: begin
        if (bus.place_flag)   flag_en  = !revealed[cur];
        else if (bus.sel_sqr) state_nx = ST_REVEAL;
      end
      ST_REVEAL: begin
        if (flag[tgt] || revealed[tgt]) begin
          state_nx = ST_PLAY;
        end else if (mines[tgt]) begin
          explode_en = 1'b1;
          state_nx   = ST_LOST;
        end else begin
          reveal_en = 1'b1;
          if (work_cnt != 4'd0) state_nx = win_hit ? ST_WON : ST_PLAY;
          else                  state_nx = ST_FLOOD;
        end
      end
      ST_FLOOD: begin
        reveal_en = !revealed[idx] && !flag[idx] && !mines[idx] && (zero_nbrs != 4'd0);
        if (idx == 8'hFF && !(changed || reveal_en))
          state_nx = win_hit ? ST_WON : ST_PLAY;
      end
      default: ;
    endcase
    if (bus.new_game) state_nx = ST_LOAD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mines          <= '0;
      revealed       <= '0;
      flag           <= '0;
      zero           <= '0;
      idx            <= '0;
      tgt            <= '0;
      changed        <= 1'b0;
      exploded_vld   <= 1'b0;
      exploded_addr  <= '0;
      mine_total     <= '0;
      flags_placed   <= '0;
      cells_revealed <= '0;
    end else if (bus.new_game) begin
      // Whole-board clear up front so the renderer never shows the previous game.
      mines          <= bus.mine_map;
      revealed       <= '0;
      flag           <= '0;
      zero           <= '0;
      idx            <= '0;
      changed        <= 1'b0;
      exploded_vld   <= 1'b0;
      mine_total     <= '0;
      flags_placed   <= '0;
      cells_revealed <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          revealed[idx] <= 1'b0;
          flag[idx]     <= 1'b0;
          mine_total    <= mine_total + 9'(mines[idx]);
          idx           <= idx + 8'd1;
        end
        ST_PLAY: begin
          if (flag_en) begin
            flag[cur]    <= !flag[cur];
            flags_placed <= flag[cur] ? flags_placed - 9'd1 : flags_placed + 9'd1;
          end
          if (!bus.place_flag && bus.sel_sqr) tgt <= cur;
        end
        ST_REVEAL: begin
          if (explode_en) begin
            exploded_vld  <= 1'b1;
            exploded_addr <= tgt;
          end
          if (reveal_en) begin
            revealed[tgt]  <= 1'b1;
            zero[tgt]      <= (work_cnt == 4'd0);
            cells_revealed <= cr_next;
          end
          idx     <= '0;
          changed <= 1'b0;
        end
        ST_FLOOD: begin
          if (reveal_en) begin
            revealed[idx]  <= 1'b1;
            zero[idx]      <= (work_cnt == 4'd0);
            cells_revealed <= cr_next;
          end
          changed <= (idx == 8'hFF) ? 1'b0 : (changed | reveal_en);
          idx     <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_code = CELL_HIDDEN;
    if (state == ST_LOST && exploded_vld && exploded_addr == bus.rd_addr) rd_code = CELL_EXPLODED;
    else if (flag[bus.rd_addr])                                           rd_code = CELL_FLAG;
    else if (revealed[bus.rd_addr])                                       rd_code = rd_cnt;
    else if (state == ST_LOST && mines[bus.rd_addr])                      rd_code = CELL_MINE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_cell_q <= CELL_HIDDEN;
    else     rd_cell_q <= rd_code;
  end

  assign bus.rd_cell        = rd_cell_q;
  assign bus.busy           = (state == ST_LOAD) || (state == ST_REVEAL) || (state == ST_FLOOD);
  assign bus.game_won       = (state == ST_WON);
  assign bus.game_lost      = (state == ST_LOST);
  assign bus.flags_placed   = flags_placed;
  assign bus.cells_revealed = cells_revealed;

endmodule
